// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: data width, transmitter state encoding, bench item.
// UART_TX_BREAK_EN adds the BREAK state.
package UART_item_pack;

  localparam int WIDTH_DATABITS = 8;
  localparam logic TX_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
`ifdef UART_TX_BREAK_EN
    STOP,
    BREAK
`else
    STOP
`endif
  } uart_tx_state_t;

  typedef struct packed {
    logic [WIDTH_DATABITS-1:0] in;
    logic                      valid_in;
    logic                      parity_en;
    logic                      parity_odd;
    logic                      stop2;
  } UART_input_item;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high on the last clk of each bit while enabled.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        cnt <= '0;
    else if (!enable || cnt == LAST) cnt <= '0;
    else                            cnt <= cnt + CW'(1);
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits.
// UART_TX_BREAK_EN adds break_req and a BREAK state (line held low).
module uart_tx #(
  parameter int WIDTH_DATABITS = UART_item_pack::WIDTH_DATABITS,
  parameter int CLKS_PER_BIT   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH_DATABITS-1:0] in,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic                      parity_en,
  input  logic                      parity_odd,
  input  logic                      stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                      break_req,
`endif
  output logic                      tx,
  output logic                      busy,
  output logic                      done
);

  import UART_item_pack::*;

  localparam int IW = $clog2(WIDTH_DATABITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH_DATABITS - 1);

  uart_tx_state_t            state, state_n;
  logic [IW-1:0]             idx, idx_n;
  logic [WIDTH_DATABITS-1:0] data_q, data_n;
  logic                      pe_q, pe_n, po_q, po_n, s2_q, s2_n;
  logic                      tx_n, done_n, tick, baud_en;
`ifdef UART_TX_BREAK_EN
  logic                      brk_rel, brk_rel_n;
`endif

  assign ready_in = (state == IDLE);
  assign busy     = (state != IDLE);

  // In BREAK the bit-time only starts once break_req has been released.
`ifdef UART_TX_BREAK_EN
  assign baud_en = busy && !(state == BREAK && !brk_rel);
`else
  assign baud_en = busy;
`endif

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .rst    (rst),
    .enable (baud_en),
    .tick   (tick)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    data_n    = data_q;
    pe_n      = pe_q;
    po_n      = po_q;
    s2_n      = s2_q;
    done_n    = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_rel_n = brk_rel;
`endif
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (break_req) begin
          state_n   = BREAK;
          brk_rel_n = 1'b0;
        end else
`endif
        if (valid_in) begin
          state_n = START;
          idx_n   = '0;
          data_n  = in;
          pe_n    = parity_en;
          po_n    = parity_odd;
          s2_n    = stop2;
        end
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (tick) begin
        if (idx == LAST_IDX) begin
          idx_n   = '0;
          state_n = pe_q ? PARITY : STOP;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      PARITY: if (tick) state_n = STOP;
      // idx doubles as the stop-bit counter for two-stop-bit frames
      STOP: if (tick) begin
        if (s2_q && idx == '0) begin
          idx_n = IW'(1);
        end else begin
          state_n = IDLE;
          idx_n   = '0;
          done_n  = 1'b1;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (!brk_rel) begin
          if (!break_req) brk_rel_n = 1'b1;
        end else if (tick) begin
          state_n   = IDLE;
          brk_rel_n = 1'b0;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // tx is registered from the next-state view so it lines up with state
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[idx_n];
      PARITY:  tx_n = (^data_n) ^ po_n;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_n = brk_rel_n;
`endif
      default: tx_n = TX_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      data_q  <= '0;
      pe_q    <= 1'b0;
      po_q    <= 1'b0;
      s2_q    <= 1'b0;
      tx      <= TX_IDLE_LEVEL;
      done    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_rel <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      data_q  <= data_n;
      pe_q    <= pe_n;
      po_q    <= po_n;
      s2_q    <= s2_n;
      tx      <= tx_n;
      done    <= done_n;
`ifdef UART_TX_BREAK_EN
      brk_rel <= brk_rel_n;
`endif
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serialises one data word per valid/ready handshake onto a single `tx` line.
- Frame: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
- Transmit-side counterpart of the UART receiver, whose word output is `out`/`valid_out` plus `error`/`valid_error`.
- Sits between the parallel data source and the serial pin; shares `UART_item_pack` with the receiver.

Parameters:
- WIDTH_DATABITS, 8, data bits per frame; taken from `UART_item_pack`, legal range 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 2.

Ports:
- clk  input  1  system clock; all state changes on the posedge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH_DATABITS  word to transmit.
- valid_in  input  1  `in` is valid.
- ready_in  output  1  block can accept a word; high exactly when state is IDLE.
- parity_en  input  1  append a parity bit.
- parity_odd  input  1  parity sense: 1 = odd, 0 = even.
- stop2  input  1  send two stop bits instead of one.
- tx  output  1  serial line; idle level is 1.
- busy  output  1  a frame is in progress (state is not IDLE).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
Reset:
- `rst` high forces state IDLE immediately, independent of clk.
- Reset values: `tx`=1, `busy`=0, `done`=0, `ready_in`=1; bit counter and baud counter cleared.
- Reset mid-frame aborts the frame; `tx` returns high immediately; no `done` pulse.

Handshake:
- Accept occurs on a posedge with `valid_in`=1 and `ready_in`=1.
- On accept, the block latches `in`, `parity_en`, `parity_odd` and `stop2`.
- Input changes after accept do not affect the frame in flight.
- `valid_in` while not ready is ignored; no buffering.

State machine (uart_tx_state_t):
- IDLE: `tx`=1. On accept, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=data[idx], idx 0..WIDTH_DATABITS-1, each bit CLKS_PER_BIT cycles. After the last bit, go to PARITY if parity_en, else STOP.
- PARITY: `tx`=^data XOR parity_odd, held for CLKS_PER_BIT cycles.
- STOP: `tx`=1 for CLKS_PER_BIT cycles if stop2=0, or 2*CLKS_PER_BIT if stop2=1. Then go to IDLE.

Timing:
- `tx` is registered. The start bit appears on the cycle after accept.
- Frame length is (1+WIDTH_DATABITS+parity_en+1+stop2)*CLKS_PER_BIT cycles.
- `done`=1 for exactly one cycle, coincident with the first IDLE cycle after STOP.
- `ready_in`=1 in that same cycle, so back-to-back frames have zero idle bit-time between the last stop bit and the next start bit.

Baud counter:
- Counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- Held at 0 in IDLE.
- Width is $clog2(CLKS_PER_BIT).

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port `break_req`, 1 bit, and state BREAK.
  - In IDLE, `break_req`=1 takes priority over `valid_in`; next state is BREAK.
  - In BREAK: `tx`=0, `ready_in`=0, `busy`=1.
  - On `break_req`=0, the block holds `tx`=1 for one bit-time (still in BREAK), then returns to IDLE. No `done` pulse.
  - `break_req` asserted mid-frame is ignored until IDLE.
- Undefined: no `break_req` port and no BREAK state; behaviour is exactly as above.

Decomposition:
- `UART_item_pack` holds:
  - WIDTH_DATABITS (existing);
  - enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP[, BREAK]};
  - constant TX_IDLE_LEVEL=1'b1.
- `UART_input_item` carries in/valid_in/parity_en/parity_odd/stop2 for the bench.
- Sub-module uart_baud_tick:
  - parameter CLKS_PER_BIT; inputs clk, rst, enable;
  - output `tick`, high on the last cycle of each bit;
  - reused later by the receiver's oversampler.

Test Plan:
- Single frame, no parity: CLKS_PER_BIT=4, stop2=0, send 0xA5. Required `tx` bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; `done` at cycle 41 after accept; `busy` high cycles 1..40.
- Even parity: send 0x07 with parity_en=1, parity_odd=0 → parity bit 1. Same word with parity_odd=1 → parity bit 0. Frame is 44 cycles.
- Two stop bits: send 0xFF with stop2=1 → `tx` high for 8 cycles after the last data bit; frame is 44 cycles.
- Back-to-back: hold `valid_in`=1 with 0x12 then 0x34 → second accept in the cycle `done` pulses; the second start bit directly follows the first frame's stop bit.
- Ignored input and latching: `valid_in` pulse while busy produces no second frame. Changing `in`/`parity_en` mid-frame does not alter the current frame.
- Reset mid-frame: assert `rst` during DATA bit 3 → `tx`=1 asynchronously, `busy`=0, no `done` pulse; the next accept sends a clean frame.
